// File: rtl/micro_seq_if.sv
// Sequencer bus: instruction/flag inputs, control enables, table
// configuration port and the registered control-word outputs.
//   master : drives en/resume/opcode/flags/cfg_*, observes ctrl/status
//   slave  : the sequencer (micro_seq)
interface micro_seq_if #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned FLW     = 2,
  parameter int unsigned CW      = 13,
  parameter int unsigned ENTRIES = 32
);
  localparam int unsigned KW = OPW + FLW + 1;
  localparam int unsigned IW = $clog2(ENTRIES);

  logic           en;
  logic           resume;
  logic [OPW-1:0] opcode;
  logic [FLW-1:0] flags;
  logic           cfg_we;
  logic [IW-1:0]  cfg_idx;
  logic           cfg_valid;
  logic [KW-1:0]  cfg_value;
  logic [KW-1:0]  cfg_mask;
  logic [CW-1:0]  cfg_word;
  logic [CW-1:0]  ctrl;
  logic           ctrl_valid;
  logic           hit;
  logic           phase;
  logic           halted;

  modport master (
    output en, resume, opcode, flags,
    output cfg_we, cfg_idx, cfg_valid, cfg_value, cfg_mask, cfg_word,
    input  ctrl, ctrl_valid, hit, phase, halted
  );

  modport slave (
    input  en, resume, opcode, flags,
    input  cfg_we, cfg_idx, cfg_valid, cfg_value, cfg_mask, cfg_word,
    output ctrl, ctrl_valid, hit, phase, halted
  );
endinterface

// File: rtl/micro_seq.sv
// Programmable microcode sequencer. A priority-matched mask/value table
// maps {opcode, flags, phase} to a control word; a FETCH/EXEC phase FSM
// issues one registered control word per enabled cycle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears outputs and valid bits)
//   bus      micro_seq_if.slave: en, resume, opcode, flags, cfg_* table
//            write port; ctrl, ctrl_valid, hit, phase, halted outputs
// Optional feature macro: MICRO_SEQ_MISS_HALT_EN -- a table miss during
// EXEC sends the FSM to HALT after issuing DEFAULT_WORD.
module micro_seq #(
  parameter int unsigned     OPW          = 4,
  parameter int unsigned     FLW          = 2,
  parameter int unsigned     CW           = 13,
  parameter int unsigned     ENTRIES      = 32,
  parameter logic [CW-1:0]   DEFAULT_WORD = CW'(13'b1000000001000),
  parameter int unsigned     HALT_BIT     = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  micro_seq_if.slave    bus
);

  localparam int unsigned KW = OPW + FLW + 1;
  localparam int unsigned IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Table storage; only the valid bits need a reset value.
  logic [ENTRIES-1:0] valid_q;
  logic [KW-1:0]      value_q [ENTRIES];
  logic [KW-1:0]      mask_q  [ENTRIES];
  logic [CW-1:0]      word_q  [ENTRIES];

  logic [CW-1:0] ctrl_q;
  logic          ctrl_valid_q;
  logic          hit_q;
  logic          phase_q;
  logic          halted_q;

  logic [KW-1:0] key_c;
  logic          match_c;
  logic [CW-1:0] word_c;
  logic          lookup_c;
  logic          miss_halt_c;
  logic          wr_ok_c;

  // Priority match: scanning high-to-low lets the lowest index win.
  always_comb begin
    key_c   = {bus.opcode, bus.flags, (state == S_EXEC)};
    match_c = 1'b0;
    word_c  = DEFAULT_WORD;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (((key_c ^ value_q[i]) & mask_q[i]) == '0)) begin
        match_c = 1'b1;
        word_c  = word_q[i];
      end
    end
  end

`ifdef MICRO_SEQ_MISS_HALT_EN
  assign miss_halt_c = !match_c;
`else
  assign miss_halt_c = 1'b0;
`endif

  // Next state and lookup strobe.
  always_comb begin
    state_nxt = state;
    lookup_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.en) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.en) begin
          lookup_c  = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.en) begin
          lookup_c  = 1'b1;
          state_nxt = (word_c[HALT_BIT] || miss_halt_c) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (bus.resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; phase/halted follow the next state so
  // they change on the same edge as ctrl.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      phase_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state        <= state_nxt;
      ctrl_valid_q <= lookup_c;
      phase_q      <= (state_nxt == S_EXEC);
      halted_q     <= (state_nxt == S_HALT);
      if (lookup_c) begin
        ctrl_q <= word_c;
        hit_q  <= match_c;
      end
    end
  end

  // Writes beyond ENTRIES (non power-of-2 tables) are dropped.
  assign wr_ok_c = bus.cfg_we && ({1'b0, bus.cfg_idx} < (IW + 1)'(ENTRIES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (wr_ok_c) begin
      valid_q[bus.cfg_idx] <= bus.cfg_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      value_q[bus.cfg_idx] <= bus.cfg_value;
      mask_q[bus.cfg_idx]  <= bus.cfg_mask;
      word_q[bus.cfg_idx]  <= bus.cfg_word;
    end
  end

  assign bus.ctrl       = ctrl_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.hit        = hit_q;
  assign bus.phase      = phase_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_micro_seq.sv
// Directed self-checking bench for micro_seq.
module tb_micro_seq;

  localparam logic [12:0] DEF = 13'b1000000001000;
  localparam logic [12:0] W0  = 13'b0001001000010;
  localparam logic [12:0] WA  = 13'h0AA0;
  localparam logic [12:0] WB  = 13'h0550;
  localparam logic [12:0] WH  = 13'h0201;
  localparam logic [12:0] W0N = 13'h0C04;
  localparam logic [12:0] WN  = 13'h1110;
`ifdef MICRO_SEQ_MISS_HALT_EN
  localparam logic MH = 1'b1;
`else
  localparam logic MH = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  micro_seq_if #(.OPW(4), .FLW(2), .CW(13), .ENTRIES(32)) bus ();

  micro_seq #(.OPW(4), .FLW(2), .CW(13), .ENTRIES(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_set(input int idx, input logic v, input logic [6:0] val,
                         input logic [6:0] msk, input logic [12:0] wd);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 5'(idx);
    bus.cfg_valid = v;
    bus.cfg_value = val;
    bus.cfg_mask  = msk;
    bus.cfg_word  = wd;
  endtask

  // Resume is ignored outside HALT, so this lands in FETCH in either build.
  task automatic recover();
    bus.en     = 1'b0;
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    check("recover_halted", 32'(bus.halted), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    bus.en = 1'b0; bus.resume = 1'b0; bus.opcode = '0; bus.flags = '0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_valid = 1'b0;
    bus.cfg_value = '0; bus.cfg_mask = '0; bus.cfg_word = '0;
    tick(); tick();
    check("rst_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst_cv", 32'(bus.ctrl_valid), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_phase", 32'(bus.phase), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    reset_n = 1'b1;

    // Empty table
    bus.opcode = 4'h2; bus.en = 1'b1;
    tick();
    check("idle_cv", 32'(bus.ctrl_valid), 32'd0);
    check("idle_phase", 32'(bus.phase), 32'd0);
    tick();
    check("empty_f_ctrl", 32'(bus.ctrl), 32'(DEF));
    check("empty_f_hit", 32'(bus.hit), 32'd0);
    check("empty_f_cv", 32'(bus.ctrl_valid), 32'd1);
    check("empty_f_phase", 32'(bus.phase), 32'd1);
    tick();
    check("empty_e_ctrl", 32'(bus.ctrl), 32'(DEF));
    check("empty_e_hit", 32'(bus.hit), 32'd0);
    check("empty_e_phase", 32'(bus.phase), 32'd0);
    check("empty_e_halted", 32'(bus.halted), 32'(MH));
    recover();

    // Entry0 exact EXEC match
    bus.en = 1'b0;
    cfg_set(0, 1'b1, 7'b0010001, 7'h7F, W0);
    tick();
    bus.cfg_we = 1'b0;
    check("en0_cv", 32'(bus.ctrl_valid), 32'd0);
    check("en0_phase", 32'(bus.phase), 32'd0);
    bus.en = 1'b1;
    tick();
    check("e0_f_ctrl", 32'(bus.ctrl), 32'(DEF));
    check("e0_f_hit", 32'(bus.hit), 32'd0);
    tick();
    check("e0_e_ctrl", 32'(bus.ctrl), 32'(W0));
    check("e0_e_hit", 32'(bus.hit), 32'd1);
    check("e0_e_cv", 32'(bus.ctrl_valid), 32'd1);
    check("e0_e_halted", 32'(bus.halted), 32'd0);

    // Priority between overlapping entries 1 and 3
    bus.en = 1'b0;
    cfg_set(3, 1'b1, 7'b0000000, 7'b0000001, WA);
    tick();
    cfg_set(1, 1'b1, 7'b0000000, 7'h7F, WB);
    tick();
    bus.cfg_we = 1'b0;
    bus.opcode = 4'h0; bus.flags = 2'b00; bus.en = 1'b1;
    tick();
    check("prio_low_ctrl", 32'(bus.ctrl), 32'(WB));
    check("prio_low_hit", 32'(bus.hit), 32'd1);
    tick();
    check("prio_emiss_ctrl", 32'(bus.ctrl), 32'(DEF));
    recover();
    bus.opcode = 4'h4; bus.en = 1'b1;
    tick();
    check("prio_e3_ctrl", 32'(bus.ctrl), 32'(WA));
    tick();
    recover();

    // HALT via control word bit 0
    bus.en = 1'b0;
    cfg_set(2, 1'b1, 7'b0101001, 7'h7F, WH);
    tick();
    bus.cfg_we = 1'b0;
    bus.opcode = 4'h5; bus.en = 1'b1;
    tick();
    check("h_f_ctrl", 32'(bus.ctrl), 32'(WA));
    tick();
    check("h_e_ctrl", 32'(bus.ctrl), 32'(WH));
    check("h_e_halted", 32'(bus.halted), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("h_hold_cv", 32'(bus.ctrl_valid), 32'd0);
      check("h_hold_halted", 32'(bus.halted), 32'd1);
      check("h_hold_ctrl", 32'(bus.ctrl), 32'(WH));
    end
    bus.en = 1'b0; bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    check("resume_halted", 32'(bus.halted), 32'd0);
    check("resume_cv", 32'(bus.ctrl_valid), 32'd0);
    bus.en = 1'b1;
    tick();
    check("resume_f_ctrl", 32'(bus.ctrl), 32'(WA));
    check("resume_f_phase", 32'(bus.phase), 32'd1);
    bus.opcode = 4'h2;
    tick();
    check("resume_e_ctrl", 32'(bus.ctrl), 32'(W0));

    // Write to the winning entry during its own lookup
    tick();
    check("wr_f_ctrl", 32'(bus.ctrl), 32'(WA));
    cfg_set(0, 1'b1, 7'b0010001, 7'h7F, W0N);
    tick();
    bus.cfg_we = 1'b0;
    check("wr_old_word", 32'(bus.ctrl), 32'(W0));
    tick();
    tick();
    check("wr_new_word", 32'(bus.ctrl), 32'(W0N));
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_ctrl", 32'(bus.ctrl), 32'(W0N));
      check("hold_cv", 32'(bus.ctrl_valid), 32'd0);
      check("hold_phase", 32'(bus.phase), 32'd0);
    end
    bus.en = 1'b1;
    tick();
    check("hold_resume_ctrl", 32'(bus.ctrl), 32'(WA));
    check("hold_resume_phase", 32'(bus.phase), 32'd1);

    // EXEC miss
    bus.opcode = 4'h7; bus.flags = 2'b11;
    tick();
    check("miss_ctrl", 32'(bus.ctrl), 32'(DEF));
    check("miss_hit", 32'(bus.hit), 32'd0);
    check("miss_cv", 32'(bus.ctrl_valid), 32'd1);
    check("miss_halted", 32'(bus.halted), 32'(MH));
    recover();
    bus.flags = 2'b00;

    // Resume and table write together in HALT
    bus.opcode = 4'h5; bus.en = 1'b1;
    tick();
    tick();
    check("rw_halted", 32'(bus.halted), 32'd1);
    bus.en = 1'b0; bus.resume = 1'b1;
    cfg_set(0, 1'b1, 7'b0101000, 7'h7F, WN);
    tick();
    bus.resume = 1'b0; bus.cfg_we = 1'b0;
    check("rw_resume_halted", 32'(bus.halted), 32'd0);
    bus.en = 1'b1;
    tick();
    check("rw_new_ctrl", 32'(bus.ctrl), 32'(WN));
    check("rw_new_hit", 32'(bus.hit), 32'd1);

    // Asynchronous reset mid-run
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ctrl", 32'(bus.ctrl), 32'd0);
    check("arst_cv", 32'(bus.ctrl_valid), 32'd0);
    check("arst_hit", 32'(bus.hit), 32'd0);
    check("arst_phase", 32'(bus.phase), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_idle_cv", 32'(bus.ctrl_valid), 32'd0);
    tick();
    check("arst_inval_ctrl", 32'(bus.ctrl), 32'(DEF));
    check("arst_inval_hit", 32'(bus.hit), 32'd0);
    check("arst_inval_cv", 32'(bus.ctrl_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/micro_seq.md
# micro_seq

Parametrised microcode sequencer for the lab CPU datapath. It replaces the fixed combinational opcode-to-control-word table with a programmable, priority-matched, mask/value table and a FETCH/EXEC phase state machine. It registers one control word per enabled cycle. It sits between the instruction register/flag register and the datapath control inputs (PC, ALU, accumulator, bus enables).

## Interface
- OPW, 4, opcode width
- FLW, 2, flag width (C, Z)
- CW, 13, control word width
- ENTRIES, 32, table entries (≥2); IW = $clog2(ENTRIES)
- DEFAULT_WORD, 13'b1000000001000, word issued on a lookup miss
- HALT_BIT, 0, control word bit index that requests HALT
- Key width KW = OPW+FLW+1; key = {opcode, flags, phase}, phase is the LSB
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  sequencer clock enable
- resume  in  1  leave HALT
- opcode  in  OPW  current instruction opcode
- flags  in  FLW  current flags
- cfg_we  in  1  table write strobe
- cfg_idx  in  IW  entry index
- cfg_valid  in  1  valid bit written to the entry
- cfg_value  in  KW  match value
- cfg_mask  in  KW  compare mask (1 = compare bit)
- cfg_word  in  CW  control word for the entry
- ctrl  out  CW  registered control word
- ctrl_valid  out  1  one-cycle pulse: ctrl updated this cycle
- hit  out  1  registered: last lookup matched an entry
- phase  out  1  0 = FETCH, 1 = EXEC (current state)
- halted  out  1  FSM in HALT

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, reset_n=0):
  - State = IDLE.
  - ctrl = 0, ctrl_valid = 0, hit = 0, phase = 0, halted = 0.
  - All entry valid bits are cleared. Value, mask and word contents are don't-care.
- IDLE: en=1 → FETCH. No lookup is performed.
- FETCH/EXEC with en=1:
  - Lookup key = {opcode, flags, state==EXEC}.
  - Entry i matches when valid[i] and ((key ^ value[i]) & mask[i]) == 0.
  - The lowest matching index wins. Duplicate or overlapping entries are legal and resolved by this priority.
  - Hit: ctrl ← word[winner], hit ← 1.
  - Miss: ctrl ← DEFAULT_WORD, hit ← 0.
  - ctrl_valid ← 1.
- Transitions:
  - FETCH → EXEC.
  - EXEC → FETCH, unless the issued word has bit HALT_BIT = 1; then EXEC → HALT.
  - HALT_BIT in a FETCH lookup is ignored.
- en=0 in FETCH/EXEC: state holds, ctrl and hit hold, ctrl_valid = 0.
- HALT:
  - ctrl holds, ctrl_valid = 0, halted = 1.
  - resume=1 → FETCH. en is not required. Resume in any other state is ignored.
- Table writes:
  - cfg_we=1 writes {cfg_valid, cfg_value, cfg_mask, cfg_word} to entry cfg_idx at the clock edge.
  - Writes are accepted in every state, including HALT and IDLE.
  - A lookup in the same cycle as a write to the winning entry uses the pre-write contents.
  - An out-of-range cfg_idx (ENTRIES not a power of 2) is dropped.

## Timing
- Lookup latency: 1 cycle. Key inputs are sampled at edge N; ctrl, hit and ctrl_valid are valid after edge N.
- With en=1 continuously, one word issues per cycle, alternating FETCH, EXEC.
- phase and halted are registered from state. They change at the same edge as ctrl.
- reset_n asserted mid-lookup: outputs clear immediately (asynchronously). The table is invalidated. The first lookup comes one enabled cycle after IDLE.
- Simultaneous resume and cfg_we in HALT: both take effect. The FETCH lookup in the next cycle sees the new entry.

## Configuration
- MICRO_SEQ_MISS_HALT_EN
  - Defined: a miss during EXEC issues DEFAULT_WORD with hit=0, then the FSM goes to HALT. A FETCH miss behaves as below.
  - Undefined: a miss issues DEFAULT_WORD and sequencing continues normally.

## Test plan
- Reset, then en=1 with an empty table, opcode=4'h2: IDLE→FETCH→EXEC. ctrl=13'b1000000001000 and hit=0 on every lookup, phase alternates 0/1.
- Entry0 = {1, 7'b0010001, 7'h7F, 13'b0001001000010}, opcode=4'b0010, flags=2'b00, EXEC lookup: ctrl=13'b0001001000010, hit=1, ctrl_valid pulses.
- Entry3 value 7'b0000000 mask 7'b0000001 word A; entry1 value 7'b0000000 mask 7'h7F word B; key 7'b0000000: ctrl=B (lowest index wins). Key 7'b0100000: ctrl=A.
- EXEC word with bit0=1: halted=1 next cycle, ctrl_valid stays 0 for 5 cycles with en=1. resume=1 → FETCH lookup the following cycle.
- Write entry0 in the same cycle as its lookup: the old word is issued, the new word on the next matching lookup. en=0 for 3 cycles holds ctrl and state.
- MICRO_SEQ_MISS_HALT_EN defined, EXEC miss: ctrl=DEFAULT_WORD, hit=0, then halted=1. Undefined: sequencing continues to FETCH.
